// File: rtl/wisc_pkg.sv
// wisc_pkg: shared definitions for the WISC pipeline control slice.
//   - 4-bit opcode constants
//   - instruction class enum and opcode -> class helper
//   - ID-stage control bundle (ctrl_t) plus the narrower bundles
//     that are carried into EX/MEM and MEM/WB
//   - halt sequencer state encoding
package wisc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_RED  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_ROR  = 4'h6;
    localparam logic [3:0] OP_PADD = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LLB  = 4'hA;
    localparam logic [3:0] OP_LHB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_BR   = 4'hD;
    localparam logic [3:0] OP_PCS  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_LHALF,
        CLS_B,
        CLS_BR,
        CLS_PCS,
        CLS_HLT
    } op_class_e;

    // Full control bundle as produced by the ID decoder.
    typedef struct packed {
        logic alusrc;
        logic regdst;
        logic memhalf;
        logic pcs;
        logic branch;
        logic branchreg;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic halt;
        logic flagw;
    } ctrl_t;

    // Branch resolution happens in ID, so the branch bits are not carried on.
    typedef struct packed {
        logic alusrc;
        logic regdst;
        logic memhalf;
        logic pcs;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic halt;
        logic flagw;
    } ex_ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic halt;
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED
    } halt_state_e;

    function automatic op_class_e op_class(input logic [3:0] opcode);
        op_class_e cls;
        cls = CLS_ALU;
        if (opcode[3]) begin
            case (opcode)
                OP_LW:          cls = CLS_LW;
                OP_SW:          cls = CLS_SW;
                OP_LLB, OP_LHB: cls = CLS_LHALF;
                OP_B:           cls = CLS_B;
                OP_BR:          cls = CLS_BR;
                OP_PCS:         cls = CLS_PCS;
                default:        cls = CLS_HLT;
            endcase
        end
        return cls;
    endfunction

    // Shifts/rotates read only src1; the other ALU ops read both sources.
    function automatic logic is_shift(input logic [3:0] opcode);
        return (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control bundle for the ID stage.
// Ports:
//   valid    in   IF/ID holds a real instruction (0 -> all-zero bundle)
//   opcode   in   4-bit ID opcode
//   dst      in   ID destination register (used for r0 suppression)
//   ctrl     out  decoded control bundle
//   use_src1 out  instruction reads src1
//   use_src2 out  instruction reads src2
module ctrl_decode
    import wisc_pkg::*;
#(
    parameter int RAW      = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           valid,
    input  logic [3:0]     opcode,
    input  logic [RAW-1:0] dst,
    output ctrl_t          ctrl,
    output logic           use_src1,
    output logic           use_src2
);

    always_comb begin
        ctrl     = '0;
        use_src1 = 1'b0;
        use_src2 = 1'b0;
        if (valid) begin
            case (op_class(opcode))
                CLS_ALU: begin
                    ctrl.regdst   = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.flagw    = 1'b1;
                    use_src1      = 1'b1;
                    use_src2      = ~is_shift(opcode);
                end
                CLS_LW: begin
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.regwrite = 1'b1;
                    use_src1      = 1'b1;
                end
                CLS_SW: begin
                    ctrl.memwrite = 1'b1;
                    use_src1      = 1'b1;
                    use_src2      = 1'b1;
                end
                CLS_LHALF: begin
                    ctrl.memhalf  = 1'b1;
                    ctrl.regwrite = 1'b1;
                    use_src1      = 1'b1;
                end
                CLS_B: begin
                    ctrl.branch = 1'b1;
                end
                CLS_BR: begin
                    ctrl.branch    = 1'b1;
                    ctrl.branchreg = 1'b1;
                    use_src1       = 1'b1;
                end
                CLS_PCS: begin
                    ctrl.pcs      = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                default: begin
                    ctrl.halt = 1'b1;
                end
            endcase
            // A write to hardwired r0 is architecturally a no-op: dropping
            // regwrite here removes it from both hazard detection and WB.
            if (ZERO_REG && (dst == '0)) begin
                ctrl.regwrite = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the 16-bit WISC five-stage core.
// Decodes the ID opcode, carries the controls through ID/EX, EX/MEM and
// MEM/WB, detects load-use / branch-register / flag hazards, generates the
// IF/ID flush for taken branches, and drains the pipe on HLT.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_opcode           ID instruction valid and opcode
//   id_src1, id_src2, id_dst      ID register numbers
//   br_taken                      ID branch unit resolves taken
//   pc_stall, ifid_stall          hold PC / IF/ID
//   if_flush                      bubble into IF/ID on next edge
//   ex_alusrc, ex_regdst,
//   ex_memhalf, ex_pcs            EX-stage controls
//   mem_read, mem_write           MEM-stage controls
//   wb_regwrite, wb_memtoreg,
//   wb_dst                        WB-stage controls and destination
//   halted                        HLT reached WB (sticky until rst)
module pipe_ctrl
    import wisc_pkg::*;
#(
    parameter int RAW           = 4,
    parameter bit ZERO_REG      = 1'b1,
    parameter bit FWD_MEM_STORE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [3:0]     id_opcode,
    input  logic [RAW-1:0] id_src1,
    input  logic [RAW-1:0] id_src2,
    input  logic [RAW-1:0] id_dst,
    input  logic           br_taken,
    output logic           pc_stall,
    output logic           ifid_stall,
    output logic           if_flush,
    output logic           ex_alusrc,
    output logic           ex_regdst,
    output logic           ex_memhalf,
    output logic           ex_pcs,
    output logic           mem_read,
    output logic           mem_write,
    output logic           wb_regwrite,
    output logic           wb_memtoreg,
    output logic [RAW-1:0] wb_dst,
    output logic           halted
);

    ctrl_t          id_ctrl;
    logic           id_use1;
    logic           id_use2;

    ex_ctrl_t       ex_reg, ex_next;
    logic [RAW-1:0] ex_dst_reg, ex_dst_next;
    mem_ctrl_t      mem_reg;
    logic [RAW-1:0] mem_dst_reg;
    logic           wb_regwrite_reg;
    logic           wb_memtoreg_reg;
    logic [RAW-1:0] wb_dst_reg;

    halt_state_e    state_reg, state_next;

    logic ex_load, mem_load;
    logic lu_src1, lu_src2, store_fwd, load_use;
    logic is_br, is_b, br_stall, flag_stall;
    logic hazard, halting, stall, accept;

    ctrl_decode #(
        .RAW      (RAW),
        .ZERO_REG (ZERO_REG)
    ) u_decode (
        .valid    (id_valid),
        .opcode   (id_opcode),
        .dst      (id_dst),
        .ctrl     (id_ctrl),
        .use_src1 (id_use1),
        .use_src2 (id_use2)
    );

    // ---------------- hazard detection (combinational, ID) ----------------
    // regwrite is already cleared for r0 destinations, so it doubles as the
    // "dst != 0" qualifier.
    assign ex_load  = ex_reg.memread  & ex_reg.regwrite;
    assign mem_load = mem_reg.memread & mem_reg.regwrite;

    assign lu_src1  = ex_load & id_use1 & (ex_dst_reg == id_src1);
    assign lu_src2  = ex_load & id_use2 & (ex_dst_reg == id_src2);
    // Store data (src2) can be forwarded MEM->MEM from the load, so a store
    // depending on the load only through its data does not need to wait.
    assign store_fwd = FWD_MEM_STORE & id_ctrl.memwrite;
    assign load_use  = lu_src1 | (lu_src2 & ~store_fwd);

    assign is_br = id_ctrl.branchreg;
    assign is_b  = id_ctrl.branch & ~id_ctrl.branchreg;

    // BR resolves in ID, so its target register must already be settled:
    // any writer in EX, or a load still in MEM, holds it back.
    assign br_stall = is_br & (
                          (ex_reg.regwrite & (ex_dst_reg == id_src1)) |
                          (mem_load & (mem_dst_reg == id_src1)));
    assign flag_stall = is_b & ex_reg.flagw;

    assign hazard  = load_use | br_stall | flag_stall;
    assign halting = (state_reg != ST_RUN);
    assign stall   = hazard | halting;
    assign accept  = id_valid & ~stall;

    assign pc_stall   = stall;
    assign ifid_stall = stall;
    assign if_flush   = id_ctrl.branch & br_taken & ~stall;

    // ---------------- ID/EX next value (bubble unless accepted) ----------------
    always_comb begin
        ex_next     = '0;
        ex_dst_next = '0;
        if (accept) begin
            ex_next.alusrc   = id_ctrl.alusrc;
            ex_next.regdst   = id_ctrl.regdst;
            ex_next.memhalf  = id_ctrl.memhalf;
            ex_next.pcs      = id_ctrl.pcs;
            ex_next.memread  = id_ctrl.memread;
            ex_next.memwrite = id_ctrl.memwrite;
            ex_next.memtoreg = id_ctrl.memtoreg;
            ex_next.regwrite = id_ctrl.regwrite;
            ex_next.halt     = id_ctrl.halt;
            ex_next.flagw    = id_ctrl.flagw;
            ex_dst_next      = id_dst;
        end
    end

    // ---------------- halt sequencer ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:     if (accept && id_ctrl.halt) state_next = ST_HALTING;
            // The HLT marker sitting in MEM moves to WB on this edge.
            ST_HALTING: if (mem_reg.halt)           state_next = ST_HALTED;
            default:    state_next = ST_HALTED;
        endcase
    end

    // ---------------- stage registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            ex_reg          <= '0;
            ex_dst_reg      <= '0;
            mem_reg         <= '0;
            mem_dst_reg     <= '0;
            wb_regwrite_reg <= 1'b0;
            wb_memtoreg_reg <= 1'b0;
            wb_dst_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            ex_reg           <= ex_next;
            ex_dst_reg       <= ex_dst_next;
            mem_reg.memread  <= ex_reg.memread;
            mem_reg.memwrite <= ex_reg.memwrite;
            mem_reg.memtoreg <= ex_reg.memtoreg;
            mem_reg.regwrite <= ex_reg.regwrite;
            mem_reg.halt     <= ex_reg.halt;
            mem_dst_reg      <= ex_dst_reg;
            wb_regwrite_reg  <= mem_reg.regwrite;
            wb_memtoreg_reg  <= mem_reg.memtoreg;
            wb_dst_reg       <= mem_dst_reg;
        end
    end

    assign ex_alusrc   = ex_reg.alusrc;
    assign ex_regdst   = ex_reg.regdst;
    assign ex_memhalf  = ex_reg.memhalf;
    assign ex_pcs      = ex_reg.pcs;
    assign mem_read    = mem_reg.memread;
    assign mem_write   = mem_reg.memwrite;
    assign wb_regwrite = wb_regwrite_reg;
    assign wb_memtoreg = wb_memtoreg_reg;
    assign wb_dst      = wb_dst_reg;
    assign halted      = (state_reg == ST_HALTED);

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 16-bit WISC five-stage core: successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Detects load-use and ID-branch hazards, inserts bubbles, and generates the IF/ID flush on taken branches. Sequences halt drain and raises a sticky `halted`.

## Interface
Parameters:
- `RAW`, 4: register-address width.
- `ZERO_REG`, 1: when 1, r0 is hardwired. A write to r0 never creates a hazard and never asserts `wb_regwrite`.
- `FWD_MEM_STORE`, 1: when 1, a store whose only dependency on the EX load is its data source (src2) does not stall, because the datapath supplies MEM-MEM forwarding.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `id_opcode`  in  4  ID opcode.
- `id_src1`, `id_src2`, `id_dst`  in  `RAW` each  ID source and destination register numbers.
- `br_taken`  in  1  ID branch unit resolves taken.
- `pc_stall`  out  1  hold PC.
- `ifid_stall`  out  1  hold IF/ID.
- `if_flush`  out  1  load a bubble into IF/ID next edge.
- `ex_alusrc`, `ex_regdst`, `ex_memhalf`, `ex_pcs`  out  1 each  EX-stage controls.
- `mem_read`, `mem_write`  out  1 each  MEM-stage controls.
- `wb_regwrite`, `wb_memtoreg`  out  1 each  WB-stage controls.
- `wb_dst`  out  `RAW`  WB destination register.
- `halted`  out  1  HLT has reached WB; sticky.

## Operation
- Decode classes:
  - 0xxx ALU: RegDst, ALUSrc, RegWrite, flag writer. Uses src1 and src2; shifts 0100–0110 use src1 only.
  - 1000 LW: MemRead, MemtoReg, RegWrite. Uses src1.
  - 1001 SW: MemWrite. Uses src1 and src2.
  - 1010/1011 LLB/LHB: MemHalf, RegWrite. Uses src1.
  - 1100 B: Branch. Reads flags.
  - 1101 BR: Branch, BranchReg. Uses src1.
  - 1110 PCS: PC, RegWrite.
  - 1111 HLT.
- Load-use stall: EX holds a LW with `dst` != 0 (under `ZERO_REG`) and `dst` equals a used ID source.
  - Exception: when `FWD_MEM_STORE`=1, the ID instruction is SW and the only match is src2 → no stall.
- Branch stall, which applies to BR src1 only:
  - EX holds any register writer whose `dst` matches BR src1; or
  - MEM holds a LW whose `dst` matches BR src1.
- Flag stall: ID holds B and EX holds a flag writer.
- Stall action: `pc_stall`=`ifid_stall`=1; a bubble (all controls 0) enters ID/EX.
- Flush: `if_flush`=1 when ID holds a valid B/BR, `br_taken`=1 and there is no stall. Stall wins; `br_taken` is ignored while stalled.
- Halt:
  - Valid unstalled HLT in ID sets an internal `halting` bit. From the next cycle `pc_stall`=`ifid_stall`=1 permanently and bubbles enter ID/EX.
  - The HLT marker propagates EX→MEM→WB. `halted` asserts when it reaches WB and holds until `rst`.
- `id_valid`=0 is treated as a bubble: no hazards, zero bundle.

## Timing
- Decode and hazard logic are combinational in ID. Stall/flush outputs are valid in the same cycle.
- Bundle latency: EX controls appear 1 edge after ID acceptance, MEM controls after 2, WB controls after 3.
- Load-use stall lasts exactly 1 cycle.
- BR behind an ALU writer stalls 1 cycle. BR behind a LW stalls 2 cycles.
- `halted` rises 3 edges after the HLT is accepted in ID.
- Reset: all stage registers, `halting` and `halted` clear to 0 on the first edge with `rst`=1. All outputs then read 0.
  - `rst` mid-stall or mid-drain discards everything.

## Structure
- Shared package `wisc_pkg`:
  - opcode constants;
  - control-bundle struct (fields listed above plus `halt` and `flagw`);
  - class-decode helper.
- Sub-module `ctrl_decode`: combinational opcode → bundle plus src-use flags. Instanced once in ID.
- Top level holds the 3 stage registers, hazard compare, halt FSM: RUN→HALTING→HALTED.

## Test plan
- ADD r3←r1,r2 then SUB r4←r3,r5, both valid → no stall. `wb_regwrite`=1, `wb_dst`=3 three cycles after ADD enters ID.
- LW r2 then ADD r5←r2,r1 → one cycle `pc_stall`/`ifid_stall`. Bubble visible at `mem_read`=0 one cycle after LW's `mem_read`=1.
- LW r2 then SW r2→[r4], `FWD_MEM_STORE`=1 → no stall. With `FWD_MEM_STORE`=0 → 1-cycle stall.
- LW r7 then BR r7 with `br_taken`=1 → 2 stall cycles, then `if_flush`=1 for 1 cycle. Also: ADD r0←r1,r2 then BR r0 with `ZERO_REG`=1 → no stall.
- XOR then B with `br_taken`=1 on the stalled cycle → `if_flush`=0 while stalled, then `if_flush`=1 the following cycle.
- HLT in ID → `pc_stall` stays 1 from the next cycle and `halted`=1 at +3 edges. Pulsing `rst` one cycle later clears `halted` to 0 and all controls to 0.
